// File: rtl/capture_sequencer_pkg.sv
// Shared types and constants for the packet-capture run controller.
// Holds the FSM state encoding, stop-reason codes and counter widths.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] REASON_NONE = 2'd0;
  localparam logic [1:0] REASON_PKT  = 2'd1;
  localparam logic [1:0] REASON_CYC  = 2'd2;
  localparam logic [1:0] REASON_HOST = 2'd3;

  localparam int PKT_CNT_W  = 32;
  localparam int BYTE_CNT_W = 64;
  localparam int CYC_CNT_W  = 32;

endpackage

// File: rtl/capture_sequencer_if.sv
// Observation tap on the packet gate's AXI-Stream output.
// master drives the stream, slave only watches it.
interface capture_mon_if #(
  parameter int DW = 512
);
  logic [DW/8-1:0] MON_TKEEP;
  logic            MON_TLAST;
  logic            MON_TVALID;
  logic            MON_TREADY;

  modport master (
    output MON_TKEEP, MON_TLAST, MON_TVALID, MON_TREADY
  );

  modport slave (
    input MON_TKEEP, MON_TLAST, MON_TVALID, MON_TREADY
  );
endinterface

// File: rtl/capture_sequencer_keep_popcount.sv
// Combinational population count of a TKEEP vector (bytes valid in a beat).
// Zero latency; no handshake.
module keep_popcount #(
  parameter int W = 64
) (
  input  logic [W-1:0]             keep_i,
  output logic [$clog2(W+1)-1:0]   count_o
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(keep_i[i]);
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Capture run controller: gates the packet path and counts packets/bytes until a limit or host stop.
// enable follows start/terminate by one edge; counts land on the beat's own edge; never backpressures.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int DW           = 512,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  sys_reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PKT_CNT_W-1:0]  packet_limit,
  input  logic [CYC_CNT_W-1:0]  cycle_limit,
  output logic                  enable,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            stop_reason,
  output logic [PKT_CNT_W-1:0]  packet_count,
  output logic [BYTE_CNT_W-1:0] byte_count,
  capture_mon_if.slave          mon
);

  localparam int KW  = DW / 8;
  localparam int PCW = $clog2(KW + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  if (DRAIN_CYCLES < 8) begin : g_drain_chk
    $error("DRAIN_CYCLES must cover the gate enable synchronizer (>= 8)");
  end

  state_e                state_q, state_d;
  logic [PKT_CNT_W-1:0]  pkt_q, pkt_d;
  logic [BYTE_CNT_W-1:0] byte_q, byte_d;
  logic [CYC_CNT_W-1:0]  cyc_q, cyc_d;
  logic [PKT_CNT_W-1:0]  pkt_lim_q, pkt_lim_d;
  logic [CYC_CNT_W-1:0]  cyc_lim_q, cyc_lim_d;
  logic [DCW-1:0]        drain_q, drain_d;
  logic [1:0]            reason_q, reason_d;
  logic                  in_pkt_q, in_pkt_d;

  logic [PCW-1:0]        beat_bytes;
  logic                  beat;
  logic                  pkt_hit;
  logic                  cyc_hit;

  keep_popcount #(.W(KW)) u_popcount (
    .keep_i  (mon.MON_TKEEP),
    .count_o (beat_bytes)
  );

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    byte_d    = byte_q;
    cyc_d     = cyc_q;
    pkt_lim_d = pkt_lim_q;
    cyc_lim_d = cyc_lim_q;
    drain_d   = drain_q;
    reason_d  = reason_q;
    in_pkt_d  = in_pkt_q;

    beat = (state_q == RUN || state_q == DRAIN) && mon.MON_TVALID && mon.MON_TREADY;

    if (beat) begin
      byte_d   = byte_q + BYTE_CNT_W'(beat_bytes);
      in_pkt_d = !mon.MON_TLAST;
      if (mon.MON_TLAST && (pkt_q != '1)) begin
        pkt_d = pkt_q + PKT_CNT_W'(1);
      end
    end

    pkt_hit = beat && mon.MON_TLAST && (pkt_lim_q != '0) && (pkt_d == pkt_lim_q);
    // cyc_q counts RUN cycles already completed, so the last one sees cyc_q == limit-1
    cyc_hit = (cyc_lim_q != '0) && ((cyc_q + CYC_CNT_W'(1)) == cyc_lim_q);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          pkt_d     = '0;
          byte_d    = '0;
          cyc_d     = '0;
          reason_d  = REASON_NONE;
          in_pkt_d  = 1'b0;
          pkt_lim_d = packet_limit;
          cyc_lim_d = cycle_limit;
        end
      end
      RUN: begin
        cyc_d = cyc_q + CYC_CNT_W'(1);
        if (pkt_hit || cyc_hit || stop) begin
          state_d = DRAIN;
          drain_d = DCW'(DRAIN_CYCLES);
          if (pkt_hit)      reason_d = REASON_PKT;
          else if (cyc_hit) reason_d = REASON_CYC;
          else              reason_d = REASON_HOST;
        end
      end
      DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - DCW'(1);
        end
        // Wait out the synchronizer window and any packet still being admitted
        if ((drain_q == '0) && !in_pkt_d) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= IDLE;
      pkt_q     <= '0;
      byte_q    <= '0;
      cyc_q     <= '0;
      pkt_lim_q <= '0;
      cyc_lim_q <= '0;
      drain_q   <= '0;
      reason_q  <= REASON_NONE;
      in_pkt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      byte_q    <= byte_d;
      cyc_q     <= cyc_d;
      pkt_lim_q <= pkt_lim_d;
      cyc_lim_q <= cyc_lim_d;
      drain_q   <= drain_d;
      reason_q  <= reason_d;
      in_pkt_q  <= in_pkt_d;
    end
  end

  assign enable       = (state_q == RUN);
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign stop_reason  = reason_q;
  assign packet_count = pkt_q;
  assign byte_count   = byte_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: expected run results are queued at stimulus time
// and a monitor compares them whenever done rises.
module tb_capture_sequencer;

  localparam int DW = 512;
  localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [1:0]  reason;
    logic [31:0] pkts;
    logic [63:0] bytes;
  } exp_t;

  logic        clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] packet_limit = '0;
  logic [31:0] cycle_limit = '0;
  logic        enable;
  logic        busy;
  logic        done;
  logic [1:0]  stop_reason;
  logic [31:0] packet_count;
  logic [63:0] byte_count;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb_q[$];

  capture_mon_if #(.DW(DW)) mon ();

  capture_sequencer #(.DW(DW), .DRAIN_CYCLES(16)) dut (
    .clk          (clk),
    .sys_reset    (sys_reset),
    .start        (start),
    .stop         (stop),
    .packet_limit (packet_limit),
    .cycle_limit  (cycle_limit),
    .enable       (enable),
    .busy         (busy),
    .done         (done),
    .stop_reason  (stop_reason),
    .packet_count (packet_count),
    .byte_count   (byte_count),
    .mon          (mon)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [1:0] r, input logic [31:0] p, input logic [63:0] b);
    exp_t e;
    e.reason = r;
    e.pkts   = p;
    e.bytes  = b;
    sb_q.push_back(e);
  endtask

  task automatic run_start(input logic [31:0] pl, input logic [31:0] cl, input logic with_stop);
    @(negedge clk);
    packet_limit = pl;
    cycle_limit  = cl;
    start        = 1'b1;
    stop         = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("run_enable", 64'(enable), 64'd1);
  endtask

  task automatic beat(input logic [63:0] k, input logic l);
    mon.MON_TVALID = 1'b1;
    mon.MON_TKEEP  = k;
    mon.MON_TLAST  = l;
    @(negedge clk);
    mon.MON_TVALID = 1'b0;
    mon.MON_TLAST  = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s: done not reached within %0d cycles", name, max_cycles);
    end
    @(negedge clk);
  endtask

  // Scoreboard monitor: one queued result per completed run
  initial begin
    exp_t e;
    logic done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: done rose with no expected result queued");
        end else begin
          e = sb_q.pop_front();
          check("sb_reason", 64'(stop_reason), 64'(e.reason));
          check("sb_packets", 64'(packet_count), 64'(e.pkts));
          check("sb_bytes", byte_count, e.bytes);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    int en_cnt;
    bit seen;
    mon.MON_TREADY = 1'b1;
    mon.MON_TVALID = 1'b0;
    mon.MON_TKEEP  = '0;
    mon.MON_TLAST  = 1'b0;

    #12;
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_reason", 64'(stop_reason), 64'd0);
    check("rst_packets", 64'(packet_count), 64'd0);
    check("rst_bytes", byte_count, 64'd0);
    @(negedge clk);
    sys_reset = 1'b0;

    // Packet limit 3; a 4th packet already in flight is drained and counted
    push_exp(2'd1, 32'd4, 64'd1024);
    run_start(32'd3, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) beat(FULL, (i % 4) == 3);
    wait_done(100, "pktlim_timeout");
    check("pktlim_enable_off", 64'(enable), 64'd0);
    check("pktlim_done", 64'(done), 64'd1);

    // Cycle limit 100, no traffic: enable must stay high exactly 100 cycles
    push_exp(2'd2, 32'd0, 64'd0);
    run_start(32'd0, 32'd100, 1'b0);
    en_cnt = 0;
    seen   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (enable) en_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("cyclim_enable_cycles", 64'(en_cnt), 64'd100);
    check("cyclim_done_seen", 64'(seen), 64'd1);

    // Host stop on beat 2 of an 8-beat packet with slow trailing beats
    push_exp(2'd3, 32'd1, 64'd512);
    run_start(32'd0, 32'd0, 1'b0);
    beat(FULL, 1'b0);
    stop = 1'b1;
    beat(FULL, 1'b0);
    stop = 1'b0;
    check("hoststop_enable_off", 64'(enable), 64'd0);
    for (int b = 3; b <= 8; b++) begin
      repeat (3) @(negedge clk);
      if (b == 8) begin
        check("hoststop_hold_busy", 64'(busy), 64'd1);
        check("hoststop_hold_done", 64'(done), 64'd0);
      end
      beat(FULL, b == 8);
    end
    check("hoststop_done_at_tlast", 64'(done), 64'd1);

    // Packet-limit TLAST lands in the last cycle of a 5-cycle run
    push_exp(2'd1, 32'd1, 64'd64);
    run_start(32'd1, 32'd5, 1'b0);
    repeat (4) @(negedge clk);
    check("simul_still_run", 64'(enable), 64'd1);
    beat(FULL, 1'b1);
    check("simul_enable_off", 64'(enable), 64'd0);
    wait_done(50, "simul_timeout");

    // Single-beat packet with only 8 bytes valid
    push_exp(2'd1, 32'd1, 64'd8);
    run_start(32'd1, 32'd0, 1'b0);
    beat(64'h0000_0000_0000_00FF, 1'b1);
    wait_done(50, "partial_timeout");

    // Reset mid-run, then start+stop together from IDLE
    run_start(32'd0, 32'd0, 1'b0);
    beat(FULL, 1'b1);
    check("mid_packets", 64'(packet_count), 64'd1);
    check("mid_bytes", byte_count, 64'd64);
    #2;
    sys_reset = 1'b1;
    #1;
    check("arst_enable", 64'(enable), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_packets", 64'(packet_count), 64'd0);
    check("arst_bytes", byte_count, 64'd0);
    @(negedge clk);
    sys_reset = 1'b0;
    push_exp(2'd3, 32'd1, 64'd4);
    run_start(32'd0, 32'd0, 1'b1);
    check("restart_busy", 64'(busy), 64'd1);
    beat(64'h0000_0000_0000_000F, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(50, "restart_timeout");

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
